// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive frame FIFO.
package eth_rx_pkg;
   typedef enum logic [1:0] {W_IDLE, W_PRE, W_FRAME, W_DROP} wr_state_t;

   localparam logic [7:0] ETH_PREAMBLE = 8'h55;
   localparam logic [7:0] ETH_SFD      = 8'hD5;
   localparam int         ETH_MIN_LEN  = 64;
   localparam int         ETH_MAX_LEN  = 1518;
   localparam int         ETH_LEN_W    = 11;
endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port, single clock.
module eth_sdp_ram #(
   parameter int ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);
   logic [7:0] mem_q [2**ADDR_W];
   logic [7:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive buffer: strips preamble/SFD, commits good frames,
// discards bad ones, and streams committed frames out with their length.
module eth_rx_frame_fifo #(
   parameter int ADDR_W  = 12,
   parameter int DESC_W  = 4,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        i_rx_clk,
   input  logic        i_rst_n,
   input  logic        i_rx_dv,
   input  logic        i_rx_er,
   input  logic [7:0]  i_rx_d,
   output logic        o_rd_valid,
   input  logic        i_rd_ready,
   output logic [7:0]  o_rd_data,
   output logic        o_rd_last,
   output logic [10:0] o_rd_len,
   output logic [15:0] o_frame_cnt,
   output logic [15:0] o_drop_cnt,
   output logic        o_drop
);
   import eth_rx_pkg::*;

   localparam int PW = ADDR_W + 1;
   localparam int DD = 2**DESC_W;
   localparam logic [ADDR_W:0]    RAM_FULL  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [DESC_W:0]    DESC_FULL = {1'b1, {DESC_W{1'b0}}};
   localparam logic [ETH_LEN_W-1:0] LEN_MIN = ETH_LEN_W'(MIN_LEN);
   localparam logic [ETH_LEN_W-1:0] LEN_MAX = ETH_LEN_W'(MAX_LEN);

   wr_state_t             st_q, st_d;
   logic [ADDR_W:0]       wr_q, wr_d, tmp_q, tmp_d, rd_q, used;
   logic [ETH_LEN_W-1:0]  len_q, len_d;
   logic                  ram_we, commit, drop, ram_full, desc_full;
   logic [15:0]           frame_cnt_q, drop_cnt_q;
   logic                  drop_q;

   logic [ETH_LEN_W-1:0]  desc_q [DD];
   logic [DESC_W:0]       dwr_q, drd_q, dfet_q;

   logic [ADDR_W:0]       fptr_q;
   logic [ETH_LEN_W-1:0]  fidx_q, fetch_len;
   logic                  inf_q, inf_last_q, issue, fetch_last, pop;
   logic [7:0]            ram_rdata;
   logic [7:0]            bd_q [2];
   logic                  bl_q [2];
   logic                  bwp_q, brp_q;
   logic [1:0]            bcnt_q, occ;

   assign used      = tmp_q - rd_q;
   assign ram_full  = (used == RAM_FULL);
   assign desc_full = ((dwr_q - drd_q) == DESC_FULL);

   always_comb begin
      st_d   = st_q;
      tmp_d  = tmp_q;
      wr_d   = wr_q;
      len_d  = len_q;
      ram_we = 1'b0;
      commit = 1'b0;
      drop   = 1'b0;
      case (st_q)
         W_IDLE: if (i_rx_dv) begin
            if (i_rx_er)                  st_d = W_DROP;
            else if (i_rx_d == ETH_PREAMBLE) st_d = W_PRE;
            else if (i_rx_d == ETH_SFD) begin
               st_d  = W_FRAME;
               tmp_d = wr_q;
               len_d = '0;
            end else                      st_d = W_DROP;
         end
         W_PRE: begin
            if (!i_rx_dv)                 st_d = W_IDLE;
            else if (i_rx_er)             st_d = W_DROP;
            else if (i_rx_d == ETH_SFD) begin
               st_d  = W_FRAME;
               tmp_d = wr_q;
               len_d = '0;
            end else if (i_rx_d != ETH_PREAMBLE) st_d = W_DROP;
         end
         W_FRAME: begin
            if (i_rx_dv) begin
               if (i_rx_er || ram_full || len_q == LEN_MAX) begin
                  drop  = 1'b1;
                  tmp_d = wr_q;
                  st_d  = W_DROP;
               end else begin
                  ram_we = 1'b1;
                  tmp_d  = tmp_q + 1'b1;
                  len_d  = len_q + 1'b1;
               end
            end else begin
               st_d = W_IDLE;
               if (len_q < LEN_MIN || desc_full) begin
                  drop  = 1'b1;
                  tmp_d = wr_q;
               end else begin
                  commit = 1'b1;
                  wr_d   = tmp_q;
               end
            end
         end
         W_DROP: if (!i_rx_dv) st_d = W_IDLE;
         default: st_d = W_DROP;
      endcase
   end

   // Prefetch: keep up to two bytes buffered or in flight so reads never bubble.
   assign pop        = o_rd_valid & i_rd_ready;
   assign occ        = bcnt_q + {1'b0, inf_q} - {1'b0, pop};
   assign fetch_len  = desc_q[dfet_q[DESC_W-1:0]];
   assign fetch_last = (fidx_q == fetch_len - 1'b1);
   assign issue      = (dfet_q != dwr_q) && (occ < 2'd2);

   eth_sdp_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk_i   (i_rx_clk),
      .we_i    (ram_we),
      .waddr_i (tmp_q[ADDR_W-1:0]),
      .wdata_i (i_rx_d),
      .re_i    (issue),
      .raddr_i (fptr_q[ADDR_W-1:0]),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge i_rx_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         st_q        <= W_DROP;
         wr_q        <= '0;
         tmp_q       <= '0;
         rd_q        <= '0;
         len_q       <= '0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
         drop_q      <= 1'b0;
         dwr_q       <= '0;
         drd_q       <= '0;
         dfet_q      <= '0;
         fptr_q      <= '0;
         fidx_q      <= '0;
         inf_q       <= 1'b0;
         inf_last_q  <= 1'b0;
         bwp_q       <= 1'b0;
         brp_q       <= 1'b0;
         bcnt_q      <= '0;
         for (int i = 0; i < DD; i++) desc_q[i] <= '0;
         for (int i = 0; i < 2; i++) begin
            bd_q[i] <= '0;
            bl_q[i] <= 1'b0;
         end
      end else begin
         st_q   <= st_d;
         wr_q   <= wr_d;
         tmp_q  <= tmp_d;
         len_q  <= len_d;
         drop_q <= drop;
         if (drop) drop_cnt_q <= drop_cnt_q + 1'b1;
         if (commit) begin
            desc_q[dwr_q[DESC_W-1:0]] <= len_q;
            dwr_q       <= dwr_q + 1'b1;
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
         inf_q      <= issue;
         inf_last_q <= fetch_last;
         if (issue) begin
            fptr_q <= fptr_q + 1'b1;
            if (fetch_last) begin
               fidx_q <= '0;
               dfet_q <= dfet_q + 1'b1;
            end else begin
               fidx_q <= fidx_q + 1'b1;
            end
         end
         if (inf_q) begin
            bd_q[bwp_q] <= ram_rdata;
            bl_q[bwp_q] <= inf_last_q;
            bwp_q       <= ~bwp_q;
         end
         bcnt_q <= bcnt_q + {1'b0, inf_q} - {1'b0, pop};
         if (pop) begin
            brp_q <= ~brp_q;
            if (o_rd_last) begin
               drd_q <= drd_q + 1'b1;
               rd_q  <= rd_q + PW'(o_rd_len);
            end
         end
      end
   end

   assign o_rd_valid  = (bcnt_q != 2'd0);
   assign o_rd_data   = bd_q[brp_q];
   assign o_rd_last   = bl_q[brp_q];
   assign o_rd_len    = desc_q[drd_q[DESC_W-1:0]];
   assign o_frame_cnt = frame_cnt_q;
   assign o_drop_cnt  = drop_cnt_q;
   assign o_drop      = drop_q;
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Scoreboard bench for eth_rx_frame_fifo: expected bytes queued per good frame.
module tb_eth_rx_frame_fifo;
   logic        clk = 1'b0, rst_n = 1'b0, dv = 1'b0, er = 1'b0, rdy = 1'b0;
   logic [7:0]  d = 8'h00;
   logic        o_rd_valid, o_rd_last, o_drop;
   logic [7:0]  o_rd_data;
   logic [10:0] o_rd_len;
   logic [15:0] o_frame_cnt, o_drop_cnt;

   always #5 clk = ~clk;

   eth_rx_frame_fifo dut (
      .i_rx_clk(clk), .i_rst_n(rst_n), .i_rx_dv(dv), .i_rx_er(er), .i_rx_d(d),
      .o_rd_valid(o_rd_valid), .i_rd_ready(rdy), .o_rd_data(o_rd_data),
      .o_rd_last(o_rd_last), .o_rd_len(o_rd_len), .o_frame_cnt(o_frame_cnt),
      .o_drop_cnt(o_drop_cnt), .o_drop(o_drop)
   );

   typedef struct packed {logic [7:0] d; logic last; logic [10:0] len;} exp_t;
   exp_t sb[$];

   int checks = 0, fails = 0;
   int rdy_mode = 0, drop_seen = 0, last_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Consumer ready: 0 = always, 1 = never, 2 = one cycle in three.
   initial begin
      int ph = 0;
      forever begin
         @(posedge clk); #1;
         ph = (ph + 1) % 3;
         rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : (ph == 0);
      end
   end

   // Output monitor: scoreboard compare, stall stability, no bubbles in a frame.
   initial begin
      logic       in_frame = 1'b0, prev_stall = 1'b0, pl = 1'b0;
      logic [7:0] pd = 8'h00;
      logic [10:0] plen = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 1'b0; prev_stall = 1'b0; drop_seen = 0; last_seen = 0;
         end else begin
            if (o_drop) drop_seen++;
            if (in_frame) chk("no_bubble", o_rd_valid, 1);
            if (prev_stall) begin
               chk("stall_data", o_rd_data, pd);
               chk("stall_last", o_rd_last, pl);
               chk("stall_len", o_rd_len, plen);
            end
            if (o_rd_valid && rdy) begin
               chk("sb_nonempty", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("rd_data", o_rd_data, e.d);
                  chk("rd_last", o_rd_last, e.last);
                  chk("rd_len", o_rd_len, e.len);
               end
               if (o_rd_last) last_seen++;
            end
            prev_stall = o_rd_valid && !rdy;
            pd = o_rd_data; pl = o_rd_last; plen = o_rd_len;
            in_frame = o_rd_valid && !(rdy && o_rd_last);
         end
      end
   end

   task automatic drive(input logic v, input logic e, input logic [7:0] b);
      @(posedge clk); #1;
      dv = v; er = e; d = b;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'h00);
   endtask

   // Preamble, SFD, n bytes (base+i), dv low; queues expectation when good.
   task automatic send_frame(input int n, input int er_at, input logic [7:0] base, input bit good);
      exp_t e;
      repeat (7) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < n; i++) drive(1'b1, i == er_at, base + 8'(i));
      drive(1'b0, 1'b0, 8'h00);
      if (good)
         for (int i = 0; i < n; i++) begin
            e.d = base + 8'(i); e.last = (i == n - 1); e.len = 11'(n);
            sb.push_back(e);
         end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; dv = 1'b0; er = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (sb.size() > 0 && k < budget) begin
         @(posedge clk); k++;
      end
      chk("drain_done", sb.size(), 0);
      idle(4);
   endtask

   initial begin
      int k;
      // 1: good 64-byte frame, reset values, commit-to-valid latency
      do_reset();
      @(negedge clk);
      chk("rst_valid", o_rd_valid, 0);
      chk("rst_frame_cnt", o_frame_cnt, 0);
      chk("rst_drop_cnt", o_drop_cnt, 0);
      chk("rst_drop", o_drop, 0);
      chk("rst_len", o_rd_len, 0);
      rdy_mode = 0;
      send_frame(64, -1, 8'h00, 1);
      k = 0;
      while (!o_rd_valid && k < 10) begin @(negedge clk); k++; end
      chk("commit_latency", k <= 5, 1);
      wait_drain(200);
      chk("t1_frame_cnt", o_frame_cnt, 1);
      chk("t1_drop_cnt", o_drop_cnt, 0);
      chk("t1_lasts", last_seen, 1);

      // 2: runt, then good frame
      do_reset();
      send_frame(63, -1, 8'h00, 0);
      idle(20);
      chk("t2_no_valid", o_rd_valid, 0);
      chk("t2_drop_pulses", drop_seen, 1);
      chk("t2_drop_cnt", o_drop_cnt, 1);
      send_frame(64, -1, 8'h80, 1);
      wait_drain(200);
      chk("t2_frame_cnt", o_frame_cnt, 1);

      // 3: error mid-frame, then max-length frame commits
      do_reset();
      send_frame(100, 50, 8'h10, 0);
      idle(10);
      chk("t3_drop_cnt", o_drop_cnt, 1);
      chk("t3_no_valid", o_rd_valid, 0);
      send_frame(1518, -1, 8'h03, 1);
      wait_drain(3000);
      chk("t3_frame_cnt", o_frame_cnt, 1);
      chk("t3_lasts", last_seen, 1);

      // 4: oversize
      do_reset();
      send_frame(1519, -1, 8'h00, 0);
      idle(10);
      chk("t4_drop_cnt", o_drop_cnt, 1);
      chk("t4_drop_pulses", drop_seen, 1);
      chk("t4_frame_cnt", o_frame_cnt, 0);
      chk("t4_no_valid", o_rd_valid, 0);

      // 5: backpressure fills RAM, third frame overflows, then throttled drain
      do_reset();
      rdy_mode = 1;
      send_frame(1518, -1, 8'h00, 1); idle(12);
      send_frame(1518, -1, 8'h40, 1); idle(12);
      send_frame(1518, -1, 8'h80, 0); idle(12);
      chk("t5_frame_cnt", o_frame_cnt, 2);
      chk("t5_drop_cnt", o_drop_cnt, 1);
      chk("t5_valid", o_rd_valid, 1);
      chk("t5_len", o_rd_len, 1518);
      rdy_mode = 2;
      wait_drain(12000);
      chk("t5_lasts", last_seen, 2);
      rdy_mode = 0;

      // 6: reset mid-frame, release while dv still high
      do_reset();
      repeat (7) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < 80; i++) begin
         if (i == 30) rst_n = 1'b0;
         if (i == 33) rst_n = 1'b1;
         drive(1'b1, 1'b0, 8'(i));
      end
      idle(12);
      chk("t6_frame_cnt", o_frame_cnt, 0);
      chk("t6_drop_cnt", o_drop_cnt, 0);
      chk("t6_drop_pulses", drop_seen, 0);
      chk("t6_no_valid", o_rd_valid, 0);
      send_frame(64, -1, 8'hC0, 1);
      wait_drain(200);
      chk("t6_frame_cnt2", o_frame_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/eth_rx_frame_fifo.md
Name: eth_rx_frame_fifo

Overview:
Store-and-forward receive buffer that consumes the byte stream from the Ethernet receive frame parser (its delayed GMII-style data/dv/er outputs). It strips the preamble and SFD, buffers the frame bytes (DA through FCS), and commits good frames or discards bad ones. Committed frames are presented to the switch core on a valid/ready byte interface, with a per-frame length.

Parameters:
ADDR_W, 12, log2 of data RAM depth in bytes (4096)
DESC_W, 4, log2 of length-descriptor FIFO depth (16 frames)
MIN_LEN, 64, minimum legal frame length in bytes, including FCS
MAX_LEN, 1518, maximum legal frame length in bytes, including FCS

Ports:
i_rx_clk  in  1  receive clock; all logic in this single domain
i_rst_n  in  1  asynchronous, active-low reset
i_rx_dv  in  1  byte valid from parser
i_rx_er  in  1  byte error from parser
i_rx_d  in  8  byte from parser
o_rd_valid  out  1  output byte valid
i_rd_ready  in  1  consumer ready
o_rd_data  out  8  output byte
o_rd_last  out  1  final byte (last FCS byte) of frame
o_rd_len  out  11  length of head frame; valid whenever o_rd_valid=1
o_frame_cnt  out  16  committed frames, wraps
o_drop_cnt  out  16  dropped frames, wraps
o_drop  out  1  one-cycle pulse per dropped frame

Behaviour:
- Reset (async assert, sync release): all pointers, counters and outputs are 0. Write FSM resets to W_DROP, so a frame in flight at reset release is ignored until i_rx_dv goes low. This drop is not counted.
- Write FSM states: W_IDLE, W_PRE, W_FRAME, W_DROP. "Byte" means a cycle with i_rx_dv=1.
- W_IDLE:
  - byte 0x55 -> W_PRE
  - byte 0xD5 -> W_FRAME (short preamble accepted)
  - any other byte, or i_rx_er=1 -> W_DROP (not counted)
- W_PRE:
  - 0x55 stays in W_PRE
  - 0xD5 -> W_FRAME; the temporary write pointer is loaded from the committed write pointer and len is cleared
  - i_rx_dv=0 -> W_IDLE
  - any other byte, or i_rx_er=1 -> W_DROP (not counted)
- W_FRAME:
  - each byte with i_rx_er=0 is written at the temporary pointer; pointer and len each increment by 1.
  - Abort to W_DROP, rewinding the temporary pointer and counting a drop, on any of:
    - i_rx_er=1 on any byte;
    - RAM free space is 0 when a byte arrives;
    - len would exceed MAX_LEN.
  - i_rx_dv=0 ends the frame:
    - len < MIN_LEN, or descriptor FIFO full -> drop (counted), go to W_IDLE;
    - otherwise commit in that cycle: committed write pointer <= temporary pointer, push len, increment o_frame_cnt, go to W_IDLE.
- W_DROP: stay until i_rx_dv=0, then go to W_IDLE.
- o_drop and o_drop_cnt update in the same cycle as the drop decision. Counted drops only.
- Pointers are ADDR_W+1 bits; the MSB distinguishes full from empty.
  - free = 2^ADDR_W - (tmp_wr - rd), modulo 2^(ADDR_W+1).
  - Full means free = 0. Pointers wrap naturally.
- Read side:
  - o_rd_valid asserts no later than 3 cycles after the commit edge, when the descriptor FIFO is non-empty.
  - Once asserted for a frame, o_rd_valid stays high until the last byte transfers. No bubbles inside a frame; the prefetch/skid register in front of the registered RAM read provides this.
  - A transfer occurs when o_rd_valid & i_rd_ready.
  - o_rd_data, o_rd_last and o_rd_len hold stable while o_rd_valid=1 and i_rd_ready=0.
  - o_rd_last=1 on the transfer whose byte index equals o_rd_len-1. On that transfer the descriptor is popped and rd advances.
  - The next frame may follow on the next cycle; o_rd_valid may stay high across the frame boundary.
- Simultaneous events:
  - Commit and pop in the same cycle: both take effect, and descriptor occupancy is unchanged.
  - RAM write and read of different addresses in the same cycle are always legal. The same address cannot occur, since uncommitted space never overlaps unread data.
  - Byte counts and o_rd_len include the FCS. The FCS is not checked here; the parser flags CRC errors via i_rx_er.

Decomposition:
- Package eth_rx_pkg:
  - write FSM enum wr_state_t;
  - constants ETH_PREAMBLE=8'h55 and ETH_SFD=8'hD5;
  - default MIN_LEN/MAX_LEN values;
  - ETH_LEN_W=11.
- One sub-module eth_sdp_ram: simple dual-port RAM, 2^ADDR_W x 8, one write port and one registered read port, same clock. The descriptor FIFO stays inline as a small register array.

Test Plan:
1. Good frame: reset, 7x0x55, 0xD5, then 64 bytes 0x00..0x3F with dv low after -> o_rd_len=64, bytes 0x00..0x3F in order, o_rd_last on 0x3F, o_frame_cnt=1, o_drop_cnt=0.
2. Runt frame: preamble+SFD then 63 bytes -> no o_rd_valid, o_drop pulses once, o_drop_cnt=1. A following 64-byte frame is read out intact.
3. Error mid-frame: 100-byte frame with i_rx_er=1 on byte 50 -> drop counted. Free space is restored (a next 1518-byte frame commits with len 1518).
4. Oversize: 1519 bytes after SFD -> drop on byte 1519, rest ignored until dv low, o_drop_cnt=1.
5. Backpressure/overflow, ADDR_W=12, i_rd_ready=0: 2 frames of 1518 commit; 3rd 1518 overflows -> drop. Release i_rd_ready toggling 1-of-3 cycles -> 3036 bytes with two o_rd_last, no data change while stalled.
6. Reset mid-frame: assert i_rst_n=0 at byte 30 of a frame and release while dv is still high -> remainder ignored, counters 0, the next full frame commits normally.
